wb_cmd_fifo: RTL and testbench
==============================

# wb_cmd_fifo

Wishbone-to-controller write FIFO for the user project: the firmware-to-hardware direction alongside the existing read-side data FIFO. The CPU issues Wishbone writes into user-project address space, and each accepted word is buffered in a small circular FIFO. The controller/arbiter drains words through a valid/ready pop port. A status word (fill count, full, empty) is readable over the same Wishbone slave.

## Interface

Parameters:
- DEPTH, 4, number of 32-bit entries; power of 2, 2..16
- AW, 2, log2(DEPTH); pointer width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_adr_i  in  32  Wishbone address
- wbs_dat_i  in  32  Wishbone write data
- wbs_ack_o  out  1  Wishbone acknowledge; registered, one-cycle pulse
- wbs_dat_o  out  32  Wishbone read data; registered, zero except on status-read ack
- abt_req  out  1  to arbiter; high while FIFO is non-empty (equals brc_out_valid)
- brc_out_valid  out  1  to controller; head entry valid
- brc_out_ready  in  1  from controller; pops head when brc_out_valid is also high
- Do  out  32  head entry data; 32'd0 when empty
- fill_count  out  AW+1  number of stored entries, 0..DEPTH

## Operation

- Decode: sel_u1 = &wbs_adr_i[14:12]; access = wbs_stb_i & wbs_cyc_i & sel_u1 & ~wbs_ack_o.
- Push request: access & wbs_we_i & (wbs_adr_i[3:2]==2'b00).
- Status read: access & ~wbs_we_i & (wbs_adr_i[3:2]==2'b01).
- All other decoded accesses (other offsets, reads of offset 0, writes of offset 1) get an ack with wbs_dat_o=0 and no side effect; the bus never hangs.
- Push request accepted only when full==0. On acceptance: mem[wr_ptr]<=wbs_dat_i, wr_ptr++, and ack asserts on the next cycle.
- When full, no ack is issued. The master holds stb/cyc and the push is accepted on the first cycle in which full==0.
- Status word: {16'd0, 8'(fill_count), 6'd0, full, empty}, latched into wbs_dat_o with the ack.
- Pop: when brc_out_valid & brc_out_ready, rd_ptr++.
- Do = mem[rd_ptr] combinationally (show-ahead), gated to 0 when empty.
- Pointers are AW bits and wrap modulo DEPTH.
- fill_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- full = (fill_count==DEPTH); empty = (fill_count==0).
- Simultaneous push and pop: both occur. fill_count is unchanged.
- Full/pop interaction: full is evaluated on current-cycle state. A push when full is not accepted in the same cycle as a pop; it is accepted the following cycle.
- Pop when empty: ignored; brc_out_valid is 0.
- Reset (any time, including mid-transaction): pointers, fill_count, wbs_ack_o, wbs_dat_o and Do go to 0; FIFO contents are discarded. Memory array is not reset. A pending master must retry.

## Timing

- Reset values: wbs_ack_o=0, wbs_dat_o=0, abt_req=0, brc_out_valid=0, Do=0, fill_count=0.
- Write latency: stb in cycle N with space available -> ack in cycle N+1. In N+1 the entry is already visible on Do if the FIFO was empty.
- ack is exactly one cycle wide. Because access is masked by ack, back-to-back pushes occur at most every 2 cycles.
- Status read: ack and data in cycle N+1, reflecting counts sampled in cycle N.
- wbs_dat_o returns to 0 in the cycle after an ack.
- Pop: brc_out_valid/Do update the cycle after a handshake. Continuous ready drains one word per cycle.
- Full stall: ack arrives the cycle after the first cycle in which fill_count<DEPTH.

## Test plan

- Reset then single write 0xA5A5_0001 to adr 0x3000_7000 with ready=0 -> ack at N+1 only; brc_out_valid=1; Do=0xA5A5_0001; fill_count=1.
- Write 4 words 0x1..0x4 with ready=0, then a 5th word 0x5 -> 5th stalls with no ack. Raise ready for one cycle -> pop 0x1, then ack for 0x5. Drain with ready=1 -> Do sequence 2,3,4,5, then empty with Do=0.
- Wrap-around: 10 write/pop pairs with ready held 1 -> all words out in order; fill_count never exceeds 1; pointers wrap twice.
- Status read at adr 0x3000_7004 with 3 entries stored -> wbs_dat_o=0x0000_0300 with ack; next cycle wbs_dat_o=0. Read when empty -> 0x0000_0001. Read when full -> 0x0000_0402.
- Simultaneous push and pop at fill_count=2 -> fill_count stays 2; order preserved. Access to adr[14:12]!=3'b111 -> no ack, no state change.
- Assert rst while fill_count=3 with an ack pending -> ack, wbs_dat_o, Do and fill_count are 0 immediately; after release a new write behaves as the first test.

Source files
------------

// File: rtl/wb_cmd_fifo.sv
// Wishbone-to-controller write FIFO: CPU writes are buffered in a circular
// buffer and drained through a show-ahead valid/ready pop port.
module wb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          abt_req,
  output logic          brc_out_valid,
  input  logic          brc_out_ready,
  output logic [31:0]   Do,
  output logic [AW:0]   fill_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          sel_u1;
  logic          access;
  logic          push_req;
  logic          stat_rd;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [31:0]   status;
  logic          unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:15], wbs_adr_i[11:4], wbs_adr_i[1:0]};

  assign sel_u1   = &wbs_adr_i[14:12];
  assign access   = wbs_stb_i & wbs_cyc_i & sel_u1 & ~wbs_ack_o;
  assign push_req = access & wbs_we_i & (wbs_adr_i[3:2] == 2'b00);
  assign stat_rd  = access & ~wbs_we_i & (wbs_adr_i[3:2] == 2'b01);

  assign full  = (fill_count == FULL_COUNT);
  assign empty = (fill_count == '0);

  // full uses current-cycle count, so a push blocked by full waits a cycle even if popped now
  assign push = push_req & ~full;
  assign pop  = brc_out_valid & brc_out_ready;

  assign status = {16'd0, 8'(fill_count), 6'd0, full, empty};

  assign brc_out_valid = ~empty;
  assign abt_req       = ~empty;
  assign Do            = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
    end else begin
      // A stalled push withholds ack; every other decoded access is acked at once
      wbs_ack_o <= access & ~(push_req & full);
      wbs_dat_o <= stat_rd ? status : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_count <= fill_count + 1'b1;
        2'b01:   fill_count <= fill_count - 1'b1;
        default: fill_count <= fill_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wbs_dat_i;
  end

endmodule

// File: tb/tb_wb_cmd_fifo.sv
// Self-checking bench for wb_cmd_fifo: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_wb_cmd_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        abt_req, brc_out_valid, brc_out_ready;
  logic [31:0] Do;
  logic [AW:0] fill_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] q[$];
  logic        exp_ack;
  logic [31:0] exp_dat;

  wb_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .abt_req(abt_req), .brc_out_valid(brc_out_valid), .brc_out_ready(brc_out_ready),
    .Do(Do), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_ack = 1'b0;
    exp_dat = '0;
  endtask

  task automatic check_all();
    check("ack", 32'(wbs_ack_o), 32'(exp_ack));
    check("dat_o", wbs_dat_o, exp_dat);
    check("valid", 32'(brc_out_valid), 32'(q.size() != 0));
    check("abt_req", 32'(abt_req), 32'(q.size() != 0));
    check("Do", Do, (q.size() != 0) ? q[0] : 32'd0);
    check("fill", 32'(fill_count), 32'(q.size()));
  endtask

  // One clock: model applies the rules to the inputs held over the edge
  task automatic tick();
    bit acc, preq, srd, full, empty;
    logic [31:0] st;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      acc   = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[14:12] == 3'b111) && !exp_ack;
      preq  = acc && wbs_we_i && (wbs_adr_i[3:2] == 2'b00);
      srd   = acc && !wbs_we_i && (wbs_adr_i[3:2] == 2'b01);
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      st    = {16'd0, 8'(q.size()), 6'd0, full, empty};
      exp_ack = acc && !(preq && full);
      exp_dat = srd ? st : 32'd0;
      if (brc_out_ready && !empty) void'(q.pop_front());
      if (preq && !full) q.push_back(wbs_dat_i);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_bus();
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (exp_ack) break;
    end
    if (!exp_ack) check("wb_timeout", 32'(wbs_ack_o), 32'd1);
    idle_bus();
  endtask

  task automatic do_reset_sync();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; brc_out_ready = 1'b0;
    idle_bus(); wbs_adr_i = '0; wbs_dat_i = '0;
    model_clear();
    @(negedge clk);
    do_reset_sync();
    check_all();

    // Single write, show-ahead head
    wb_access(1'b1, 32'h3000_7000, 32'hA5A5_0001);
    check("t1_do", Do, 32'hA5A5_0001);
    check("t1_fill", 32'(fill_count), 32'd1);
    brc_out_ready = 1'b1; tick(); brc_out_ready = 1'b0;

    // Fill, stall the fifth push, free one slot, then drain
    for (int i = 1; i <= 4; i++) begin
      wb_access(1'b1, 32'h3000_7000, 32'(i));
      tick();
    end
    check("full_fill", 32'(fill_count), 32'd4);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_dat_i = 32'd5;
    tick(); tick(); tick();
    check("stall_noack", 32'(wbs_ack_o), 32'd0);
    brc_out_ready = 1'b1; tick(); brc_out_ready = 1'b0;
    check("stall_noack2", 32'(wbs_ack_o), 32'd0);
    wb_access(1'b1, 32'h3000_7000, 32'd5);
    brc_out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_do", Do, 32'(i));
      tick();
    end
    check("drain_empty_do", Do, 32'd0);
    brc_out_ready = 1'b0;

    wb_access(1'b0, 32'h3000_7004, 32'd0);
    check("stat_empty", wbs_dat_o, 32'h0000_0001);
    tick();

    // Wrap-around with continuous drain
    brc_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_access(1'b1, 32'h3000_7000, 32'h100 + 32'(i));
      check("wrap_fill", 32'(fill_count <= 1), 32'd1);
      tick();
    end
    brc_out_ready = 1'b0;

    // Status at 3 and full
    for (int i = 0; i < 3; i++) begin
      wb_access(1'b1, 32'h3000_7000, 32'h200 + 32'(i));
      tick();
    end
    wb_access(1'b0, 32'h3000_7004, 32'd0);
    check("stat_3", wbs_dat_o, 32'h0000_0300);
    tick();
    check("stat_clr", wbs_dat_o, 32'd0);
    wb_access(1'b1, 32'h3000_7000, 32'h203);
    tick();
    wb_access(1'b0, 32'h3000_7004, 32'd0);
    check("stat_full", wbs_dat_o, 32'h0000_0402);
    tick();

    // Bring to 2, then simultaneous push and pop
    brc_out_ready = 1'b1; tick(); tick();
    wb_access(1'b1, 32'h3000_7000, 32'h300);
    check("simul_fill", 32'(fill_count), 32'd2);
    brc_out_ready = 1'b0;
    tick();

    // Undecoded region: no ack, no change
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_6000; wbs_dat_i = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    check("undec_ack", 32'(wbs_ack_o), 32'd0);
    check("undec_fill", 32'(fill_count), 32'd2);
    idle_bus();

    // Async reset with an ack pending
    wb_access(1'b1, 32'h3000_7000, 32'h400);
    check("pre_rst_fill", 32'(fill_count), 32'd3);
    #1 rst = 1'b1;
    model_clear();
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_do", Do, 32'd0);
    check("rst_fill", 32'(fill_count), 32'd0);
    @(negedge clk);
    do_reset_sync();
    wb_access(1'b1, 32'h3000_7000, 32'hA5A5_0001);
    check("rst_t1_do", Do, 32'hA5A5_0001);
    check("rst_t1_fill", 32'(fill_count), 32'd1);
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      wbs_stb_i = ($urandom_range(0, 3) != 0);
      wbs_cyc_i = ($urandom_range(0, 7) != 0);
      wbs_we_i  = (sel < 5);
      case ($urandom_range(0, 5))
        0, 1, 2: wbs_adr_i = 32'h3000_7000;
        3:       wbs_adr_i = 32'h3000_7004;
        4:       wbs_adr_i = 32'h3000_700C;
        default: wbs_adr_i = 32'h3000_5000;
      endcase
      wbs_dat_i     = $urandom;
      brc_out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
